// File: rtl/ula_pkg.sv
// ---------------------------------------------------------------------------
// ula_pkg
// Shared definitions for the ULA display path:
//   - ULA_W     : width of the ULA result bus (default binary input width)
//   - state_t   : states of the BCD conversion FSM
//   - SEG_*     : active-high 7-segment patterns, bit order {g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
package ula_pkg;

    localparam int ULA_W = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Active-high patterns; the decoder inverts them for active-low boards.
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/ula_seg7_dec.sv
// ---------------------------------------------------------------------------
// ula_seg7_dec
// Purely combinational BCD digit to 7-segment decoder.
// Ports:
//   bcd_digit  in  4   BCD digit (10..15 blank the display)
//   seg        out 7   segment pattern {g,f,e,d,c,b,a}
// Parameter SEG_ACTIVE_LOW selects output polarity (1: lit segment = 0).
// ---------------------------------------------------------------------------
module ula_seg7_dec
    import ula_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic [3:0] bcd_digit,
    output logic [6:0] seg
);

    logic [6:0] seg_high;

    always_comb begin
        seg_high = SEG_BLANK;
        case (bcd_digit)
            4'd0:    seg_high = SEG_0;
            4'd1:    seg_high = SEG_1;
            4'd2:    seg_high = SEG_2;
            4'd3:    seg_high = SEG_3;
            4'd4:    seg_high = SEG_4;
            4'd5:    seg_high = SEG_5;
            4'd6:    seg_high = SEG_6;
            4'd7:    seg_high = SEG_7;
            4'd8:    seg_high = SEG_8;
            4'd9:    seg_high = SEG_9;
            default: seg_high = SEG_BLANK;
        endcase
    end

    assign seg = SEG_ACTIVE_LOW ? ~seg_high : seg_high;

endmodule

// File: rtl/ula_bcd_display.sv
// ---------------------------------------------------------------------------
// ula_bcd_display
// Converts the ULA result to BCD with a sequential double-dabble (one bit per
// clock) and drives one 7-segment pattern per digit.
// Ports:
//   clk        in   1            system clock, rising edge
//   CLR        in   1            synchronous active-high reset
//   s_in       in   W_IN         unsigned value, sampled only on acceptance
//   s_valid    in   1            s_in valid; accepted when s_valid && ready
//   ready      out  1            idle, able to accept a new value
//   bcd        out  4*N_DIGITS   registered result, [3:0] = units
//   bcd_valid  out  1            one-cycle pulse when bcd is updated
//   seg        out  7*N_DIGITS   segment patterns, same digit order as bcd
// Latency: acceptance at edge E0, result and pulse at edge E0+W_IN.
// ---------------------------------------------------------------------------
module ula_bcd_display
    import ula_pkg::*;
#(
    parameter int W_IN           = ULA_W,
    parameter int N_DIGITS       = 3,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  CLR,
    input  logic [W_IN-1:0]       s_in,
    input  logic                  s_valid,
    output logic                  ready,
    output logic [4*N_DIGITS-1:0] bcd,
    output logic                  bcd_valid,
    output logic [7*N_DIGITS-1:0] seg
);

    localparam int BCD_W = 4 * N_DIGITS;
    localparam int CNT_W = $clog2(W_IN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W_IN - 1);

    state_t            state_reg,  state_next;
    logic [W_IN-1:0]   bin_sh_reg, bin_sh_next;
    logic [BCD_W-1:0]  bcd_sh_reg, bcd_sh_next;
    logic [CNT_W-1:0]  cnt_reg,    cnt_next;
    logic [BCD_W-1:0]  bcd_reg,    bcd_next;

    // Add-3 correction: a digit is at most 9 here, so the corrected value is
    // at most 12 and always fits in 4 bits.
    logic [BCD_W-1:0]       bcd_adj;
    logic [BCD_W+W_IN-1:0]  dd_shift;

    genvar gi;
    generate
        for (gi = 0; gi < N_DIGITS; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_sh_reg[gi*4 +: 4] >= 4'd5)
                                      ? (bcd_sh_reg[gi*4 +: 4] + 4'd3)
                                      :  bcd_sh_reg[gi*4 +: 4];
        end
    endgenerate

    assign dd_shift = {bcd_adj, bin_sh_reg} << 1;

    always_ff @(posedge clk) begin
        if (CLR) begin
            state_reg  <= IDLE;
            bin_sh_reg <= '0;
            bcd_sh_reg <= '0;
            cnt_reg    <= '0;
            bcd_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            bin_sh_reg <= bin_sh_next;
            bcd_sh_reg <= bcd_sh_next;
            cnt_reg    <= cnt_next;
            bcd_reg    <= bcd_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        bin_sh_next = bin_sh_reg;
        bcd_sh_next = bcd_sh_reg;
        cnt_next    = cnt_reg;
        bcd_next    = bcd_reg;
        ready       = 1'b0;
        bcd_valid   = 1'b0;

        case (state_reg)
            IDLE: begin
                ready = 1'b1;
                if (s_valid) begin
                    bin_sh_next = s_in;
                    bcd_sh_next = '0;
                    cnt_next    = '0;
                    state_next  = SHIFT;
                end
            end
            SHIFT: begin
                bcd_sh_next = dd_shift[BCD_W+W_IN-1:W_IN];
                bin_sh_next = dd_shift[W_IN-1:0];
                cnt_next    = cnt_reg + CNT_W'(1);
                // The last shift's result goes straight into bcd on the same
                // edge, so bcd and the pulse appear together.
                if (cnt_reg == CNT_LAST) begin
                    bcd_next   = dd_shift[BCD_W+W_IN-1:W_IN];
                    state_next = DONE;
                end
            end
            DONE: begin
                bcd_valid  = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bcd = bcd_reg;

    generate
        for (gi = 0; gi < N_DIGITS; gi++) begin : g_seg
            ula_seg7_dec #(
                .SEG_ACTIVE_LOW (SEG_ACTIVE_LOW)
            ) u_dec (
                .bcd_digit (bcd_reg[gi*4 +: 4]),
                .seg       (seg[gi*7 +: 7])
            );
        end
    endgenerate

endmodule

// File: tb/tb_ula_bcd_display.sv
// ---------------------------------------------------------------------------
// tb_ula_bcd_display
// Directed bench for ula_bcd_display with default parameters
// (W_IN=9, 3 digits, active-low segments). Expected values are hand-computed.
// ---------------------------------------------------------------------------
module tb_ula_bcd_display;

    logic        clk;
    logic        CLR;
    logic [8:0]  s_in;
    logic        s_valid;
    logic        ready;
    logic [11:0] bcd;
    logic        bcd_valid;
    logic [20:0] seg;

    int checks = 0;
    int errors = 0;

    ula_bcd_display dut (
        .clk       (clk),
        .CLR       (CLR),
        .s_in      (s_in),
        .s_valid   (s_valid),
        .ready     (ready),
        .bcd       (bcd),
        .bcd_valid (bcd_valid),
        .seg       (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Active-low {g,f,e,d,c,b,a} patterns written out by hand.
    function automatic logic [6:0] seg_low(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [20:0] seg_exp(input logic [11:0] b);
        return {seg_low(b[11:8]), seg_low(b[7:4]), seg_low(b[3:0])};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Single conversion from IDLE; returns in IDLE, one cycle after the pulse.
    task automatic convert(input logic [8:0] val, input logic [11:0] exp);
        s_in    = val;
        s_valid = 1'b1;
        @(negedge clk);            // edge E0 has accepted the value
        s_valid = 1'b0;
        s_in    = 'x;              // must not disturb the conversion
        check("ready_low_after_accept", {31'd0, ready}, 32'd0);
        repeat (8) @(negedge clk); // cycle E0+8
        check("no_early_valid", {31'd0, bcd_valid}, 32'd0);
        @(negedge clk);            // cycle E0+9
        check("valid_pulse", {31'd0, bcd_valid}, 32'd1);
        check("bcd_result", {20'd0, bcd}, {20'd0, exp});
        check("seg_result", {11'd0, seg}, {11'd0, seg_exp(exp)});
        check("ready_low_in_done", {31'd0, ready}, 32'd0);
        @(negedge clk);            // cycle E0+10
        check("valid_one_cycle", {31'd0, bcd_valid}, 32'd0);
        check("ready_back", {31'd0, ready}, 32'd1);
        check("bcd_hold", {20'd0, bcd}, {20'd0, exp});
        $display("conv s_in=%0d bcd=%03h expected=%03h", val, bcd, exp);
    endtask

    initial begin
        CLR     = 1'b1;
        s_valid = 1'b0;
        s_in    = '0;

        // 1. Reset
        repeat (2) @(negedge clk);
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_bcd", {20'd0, bcd}, 32'd0);
        check("rst_valid", {31'd0, bcd_valid}, 32'd0);
        check("rst_seg_units", {25'd0, seg[6:0]}, {25'd0, 7'b1000000});
        check("rst_seg_all", {11'd0, seg}, {11'd0, 21'b1000000_1000000_1000000});
        CLR = 1'b0;
        @(negedge clk);

        // 2. Small value
        convert(9'd7, 12'h007);
        check("seg_units_7", {25'd0, seg[6:0]}, {25'd0, 7'b1111000});

        // 3. Maximum and mixed values back to back
        convert(9'd511, 12'h511);
        convert(9'd255, 12'h255);
        convert(9'd100, 12'h100);

        // 4. Zero still takes the full conversion time
        convert(9'd0, 12'h000);

        // 5. s_valid while busy is dropped
        s_in    = 9'd8;
        s_valid = 1'b1;
        @(negedge clk);            // cycle E0
        s_valid = 1'b0;
        s_in    = 'x;
        repeat (2) @(negedge clk); // cycle E0+2
        s_in    = 9'd300;
        s_valid = 1'b1;
        for (int k = 3; k <= 10; k++) begin
            @(negedge clk);        // cycle E0+k
            if (k == 3) begin
                s_valid = 1'b0;
                s_in    = 'x;
            end
            check("busy_ready", {31'd0, ready}, {31'd0, k == 10});
            check("busy_valid", {31'd0, bcd_valid}, {31'd0, k == 9});
            if (k == 9) check("busy_bcd", {20'd0, bcd}, 32'h008);
        end
        $display("conv s_in=8 with dropped 300 bcd=%03h expected=008", bcd);
        repeat (12) begin
            @(negedge clk);
            check("dropped_no_valid", {31'd0, bcd_valid}, 32'd0);
        end
        check("dropped_bcd_hold", {20'd0, bcd}, 32'h008);

        // 6. Abort by CLR, then back-to-back with s_valid held high
        s_in    = 9'd123;
        s_valid = 1'b1;
        @(negedge clk);            // cycle E0
        s_valid = 1'b0;
        s_in    = 'x;
        repeat (3) @(negedge clk); // cycle E0+3
        CLR = 1'b1;
        @(negedge clk);            // reset applied at E0+4
        CLR = 1'b0;
        check("abort_ready", {31'd0, ready}, 32'd1);
        check("abort_bcd", {20'd0, bcd}, 32'd0);
        check("abort_valid", {31'd0, bcd_valid}, 32'd0);
        check("abort_seg", {11'd0, seg}, {11'd0, 21'b1000000_1000000_1000000});
        repeat (12) begin
            @(negedge clk);
            check("abort_no_valid", {31'd0, bcd_valid}, 32'd0);
        end
        $display("abort s_in=123 bcd=%03h expected=000", bcd);

        s_in    = 9'd42;
        s_valid = 1'b1;
        for (int k = 0; k <= 32; k++) begin
            @(negedge clk);        // cycle E0+k, first acceptance at E0
            check("stream_valid", {31'd0, bcd_valid}, {31'd0, (k % 11) == 9});
            check("stream_ready", {31'd0, ready}, {31'd0, (k % 11) == 10});
            if ((k % 11) == 9) begin
                check("stream_bcd", {20'd0, bcd}, 32'h042);
                $display("conv s_in=42 stream bcd=%03h expected=042", bcd);
            end
        end
        s_valid = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
